// File: rtl/shift_sequencer.sv
// Multi-cycle shift controller. It splits a total shift amount into passes of at
// most STEP_MAX and runs each pass through an external combinational shifter.
//
// state   | meaning
// IDLE    | ready for a request; in_ready high
// SHIFT   | one shifter pass per clock; work/rem updated from sh_y
// DONE    | result presented on out_data until out_ready handshake
module shift_sequencer #(
  parameter int DATA_W = 8,
  parameter int AMT_W  = 4,
  parameter int STEP_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_dir,
  input  logic [AMT_W-1:0]  in_amt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic [DATA_W-1:0] sh_a,
  output logic              sh_dir,
  output logic [STEP_W-1:0] sh_amt,
  input  logic [DATA_W-1:0] sh_y
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [AMT_W-1:0] STEP_MAX = AMT_W'((1 << STEP_W) - 1);

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] work_q, work_d;
  logic [AMT_W-1:0]  rem_q, rem_d;
  logic              dir_q, dir_d;

  logic [STEP_W-1:0] step;
  logic [AMT_W-1:0]  rem_after;

  // Step never exceeds rem, so rem cannot wrap below zero.
  always_comb begin
    step      = (rem_q > STEP_MAX) ? STEP_MAX[STEP_W-1:0] : rem_q[STEP_W-1:0];
    rem_after = rem_q - AMT_W'(step);
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    rem_d   = rem_q;
    dir_d   = dir_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          work_d  = in_data;
          rem_d   = in_amt;
          dir_d   = in_dir;
          state_d = (in_amt != '0) ? S_SHIFT : S_DONE;
        end
      end
      S_SHIFT: begin
        work_d = sh_y;
        rem_d  = rem_after;
        if (rem_after == '0) state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      work_q  <= '0;
      rem_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign out_data  = (state_q == S_DONE) ? work_q : '0;
  assign busy      = (state_q == S_SHIFT) || (state_q == S_DONE);
  assign sh_a      = work_q;
  assign sh_dir    = dir_q;
  assign sh_amt    = (state_q == S_SHIFT) ? step : '0;

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
Multi-cycle controller that performs shifts of arbitrary amount on the existing combinational 8-bit shifter, whose per-pass amount is limited to 0..3.
- Accepts a request over a valid/ready handshake.
- Drives the shifter ports with chunks of at most 2^STEP_W-1 per cycle and feeds each result back into a working register.
- Returns the final word over a second valid/ready handshake.
- Sits between a register-file/AXI-lite front end and the shifter instance; the shifter is external, connected through the sh_* ports.

Parameters:
DATA_W, 8, data word width; must equal shifter width.
AMT_W, 4, width of requested total shift amount (0..2^AMT_W-1).
STEP_W, 2, width of shifter amt port; max per-pass step STEP_MAX = 2^STEP_W-1 = 3.

Ports:
clk  input  1  system clock, all logic on rising edge.
rst_n  input  1  asynchronous active-low reset; one clock; polarity and synchronicity fixed.
in_valid  input  1  request valid.
in_ready  output  1  request accepted when in_valid & in_ready at rising edge.
in_data  input  DATA_W  operand.
in_dir  input  1  direction, passed unchanged to shifter (0 = left, 1 = right, logical, zero fill).
in_amt  input  AMT_W  total shift amount.
out_valid  output  1  result valid.
out_ready  input  1  result consumed when out_valid & out_ready at rising edge.
out_data  output  DATA_W  shifted result.
busy  output  1  high in SHIFT or DONE.
sh_a  output  DATA_W  to shifter a.
sh_dir  output  1  to shifter dir.
sh_amt  output  STEP_W  to shifter amt.
sh_y  input  DATA_W  from shifter y (combinational).

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; work, rem, dir regs cleared.
  - Outputs: out_valid 0, out_data 0, busy 0, sh_a 0, sh_dir 0, sh_amt 0, in_ready 1.
- Registers:
  - work[DATA_W]
  - rem[AMT_W]
  - dir_r
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready = 1.
  - On accept: work <= in_data, dir_r <= in_dir, rem <= in_amt.
  - Next state is SHIFT if in_amt != 0, else DONE.
- SHIFT:
  - in_ready = 0.
  - Combinational outputs: sh_a = work, sh_dir = dir_r, sh_amt = min(rem, STEP_MAX).
  - Each edge: work <= sh_y, rem <= rem - sh_amt.
  - When rem - sh_amt == 0: go to DONE; otherwise stay in SHIFT.
- DONE:
  - out_valid = 1, out_data = work, held stable until handshake.
  - On out_valid & out_ready: go to IDLE.
  - out_ready already high on entry: handshake completes in the first DONE cycle.
- Outside SHIFT: sh_amt = 0, sh_a = work, sh_dir = dir_r.
  - sh_y is sampled only in SHIFT.
- Latency:
  - Accept edge to first out_valid cycle = max(1, ceil(in_amt/STEP_MAX)) clocks.
  - Minimum one IDLE cycle between consecutive requests.
- Composition rule: the result equals the shifter applied with steps 3,3,...,remainder. Amounts >= DATA_W therefore yield 0 for the logical shifter.
- Request handling:
  - in_valid while busy is ignored; no queuing.
  - in_* changes after accept have no effect.
- Reset asserted mid-SHIFT or mid-DONE aborts immediately; no out_valid is produced afterwards for that request.
- rem never underflows, since the step is always <= rem.

Test Plan:
- Reset, then in_data=8'hAC, dir=0, amt=0 -> out_valid 1 clock after accept, out_data=8'hAC, sh_amt stays 0.
- 8'hAC, dir=0, amt=5 -> sh_amt sequence 3,2; out_data=8'h80 after 2 clocks.
- 8'hAC, dir=1, amt=7 -> sh_amt 3,3,1; out_data=8'h01 after 3 clocks. Then 8'hAC, dir=1, amt=4 -> sh_amt 3,1; out_data=8'h0A.
- 8'hAC, dir=0, amt=9 -> sh_amt 3,3,3; out_data=8'h00.
  - Hold out_ready=0 for 5 clocks: out_valid and out_data stable; in_ready=0 throughout.
  - in_valid pulsed during the hold is ignored.
- 8'hAC, dir=0, amt=15; deassert rst_n during the second SHIFT cycle:
  - All outputs go to reset values asynchronously; in_ready=1 after release.
  - Next request 8'h01, dir=0, amt=1 -> out_data=8'h02.
